// File: rtl/mmio_pkg.sv
// Shared types and constants for the MMIO register slave arbiter.
package mmio_pkg;

    localparam int MMIO_ADDR_W = 14;
    localparam int MMIO_DATA_W = 32;
    localparam int MMIO_BE_W   = MMIO_DATA_W / 8;

    // Arbiter sequencer: grant, strobe the slave, wait out its read latency, acknowledge.
    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_RESP  = 2'd3
    } mmio_arb_state_t;

    // One request bundle; used for the master-side inputs and the latched copy.
    typedef struct packed {
        logic [MMIO_ADDR_W-1:0] address;
        logic [MMIO_BE_W-1:0]   byteena;
        logic [MMIO_DATA_W-1:0] data;
        logic                   wren;
    } mmio_req_t;

    // True in every state in which a transaction is in flight.
    function automatic logic arb_is_active(input mmio_arb_state_t st);
        return (st != ARB_IDLE);
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter. Purely combinational: the caller owns the
// last-grant pointer register and feeds the updated value back when it commits.
// last_i = 1'b1 means requester 1 was served last, so requester 0 wins a tie.
module rr_arbiter2 (
    input  logic [1:0] req_i,
    input  logic       en_i,
    input  logic       last_i,
    output logic [1:0] gnt_o,
    output logic       last_o
);

    // Pick a winner when enabled; a tie goes to the requester not served last.
    always_comb begin
        gnt_o  = 2'b00;
        last_o = last_i;
        if (en_i) begin
            case (req_i)
                2'b01: begin
                    gnt_o  = 2'b01;
                    last_o = 1'b0;
                end
                2'b10: begin
                    gnt_o  = 2'b10;
                    last_o = 1'b1;
                end
                2'b11: begin
                    if (last_i) begin
                        gnt_o  = 2'b01;
                        last_o = 1'b0;
                    end else begin
                        gnt_o  = 2'b10;
                        last_o = 1'b1;
                    end
                end
                default: begin
                    gnt_o  = 2'b00;
                    last_o = last_i;
                end
            endcase
        end else begin
            gnt_o  = 2'b00;
            last_o = last_i;
        end
    end

endmodule

// File: rtl/mmio_arbiter.sv
// Shares the MMIO register slave between the CPU data port (m0) and the
// debug/loader port (m1). Each transaction takes IDLE->ISSUE->WAIT->RESP:
// a single clken strobe, one cycle for the slave's registered read, then a
// one-cycle ack with the captured read data. All outputs come from flops.
module mmio_arbiter
    import mmio_pkg::*;
#(
    parameter int ADDR_W = MMIO_ADDR_W,
    parameter int DATA_W = MMIO_DATA_W
) (
    input  logic                  clock,
    input  logic                  reset_n,

    input  logic                  m0_req,
    input  logic [ADDR_W-1:0]     m0_address,
    input  logic [DATA_W/8-1:0]   m0_byteena,
    input  logic [DATA_W-1:0]     m0_data,
    input  logic                  m0_wren,
    output logic                  m0_ack,
    output logic [DATA_W-1:0]     m0_q,

    input  logic                  m1_req,
    input  logic [ADDR_W-1:0]     m1_address,
    input  logic [DATA_W/8-1:0]   m1_byteena,
    input  logic [DATA_W-1:0]     m1_data,
    input  logic                  m1_wren,
    output logic                  m1_ack,
    output logic [DATA_W-1:0]     m1_q,

    output logic [ADDR_W-1:0]     s_address,
    output logic [DATA_W/8-1:0]   s_byteena,
    output logic [DATA_W-1:0]     s_data,
    output logic                  s_wren,
    output logic                  s_clken,
    input  logic [DATA_W-1:0]     s_q,

    output logic                  busy
);

    mmio_arb_state_t       state_q, state_d;
    mmio_req_t             lat_q, lat_d;
    logic                  sel_q, sel_d;        // granted master: 0 = m0, 1 = m1
    logic                  rr_last_q, rr_last_d;
    logic                  arb_en_s;
    logic [1:0]            gnt_s;
    mmio_req_t             m0_bundle_s, m1_bundle_s;
    logic                  issue_next_s;
    logic                  capture_s;

    logic                  s_clken_q, s_clken_d;
    logic                  s_wren_q, s_wren_d;
    logic [DATA_W/8-1:0]   s_byteena_q, s_byteena_d;
    logic [ADDR_W-1:0]     s_address_q, s_address_d;
    logic [DATA_W-1:0]     s_data_q, s_data_d;
    logic                  m0_ack_q, m0_ack_d;
    logic                  m1_ack_q, m1_ack_d;
    logic [DATA_W-1:0]     m0_rdata_q, m0_rdata_d;
    logic [DATA_W-1:0]     m1_rdata_q, m1_rdata_d;
    logic                  busy_q, busy_d;

    assign m0_bundle_s = '{address: m0_address, byteena: m0_byteena, data: m0_data, wren: m0_wren};
    assign m1_bundle_s = '{address: m1_address, byteena: m1_byteena, data: m1_data, wren: m1_wren};

    rr_arbiter2 u_rr (
        .req_i  ({m1_req, m0_req}),
        .en_i   (arb_en_s),
        .last_i (rr_last_q),
        .gnt_o  (gnt_s),
        .last_o (rr_last_d)
    );

    // Sequencer: requests are only looked at (and latched) while idle.
    always_comb begin
        state_d  = state_q;
        lat_d    = lat_q;
        sel_d    = sel_q;
        arb_en_s = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                arb_en_s = 1'b1;
                if (gnt_s[1]) begin
                    state_d = ARB_ISSUE;
                    sel_d   = 1'b1;
                    lat_d   = m1_bundle_s;
                end else if (gnt_s[0]) begin
                    state_d = ARB_ISSUE;
                    sel_d   = 1'b0;
                    lat_d   = m0_bundle_s;
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_ISSUE: state_d = ARB_WAIT;
            ARB_WAIT:  state_d = ARB_RESP;
            ARB_RESP:  state_d = ARB_IDLE;
            default:   state_d = ARB_IDLE;
        endcase
    end

    // Next values of the registered outputs, decoded from the next state so
    // that every output is a plain flop. Write strobes exist only in ISSUE.
    always_comb begin
        issue_next_s = (state_d == ARB_ISSUE);
        capture_s    = (state_q == ARB_WAIT);
        s_clken_d    = issue_next_s;
        s_wren_d     = issue_next_s ? lat_d.wren : 1'b0;
        s_byteena_d  = issue_next_s ? lat_d.byteena : {(DATA_W/8){1'b0}};
        s_address_d  = lat_d.address;
        s_data_d     = lat_d.data;
        m0_ack_d     = (state_d == ARB_RESP) && (sel_d == 1'b0);
        m1_ack_d     = (state_d == ARB_RESP) && (sel_d == 1'b1);
        m0_rdata_d   = (capture_s && (sel_q == 1'b0)) ? s_q : m0_rdata_q;
        m1_rdata_d   = (capture_s && (sel_q == 1'b1)) ? s_q : m1_rdata_q;
        busy_d       = arb_is_active(state_d);
    end

    // State, latched request and output registers; reset abandons any transaction.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ARB_IDLE;
            lat_q       <= '0;
            sel_q       <= 1'b0;
            rr_last_q   <= 1'b1;            // m0 wins the first tie
            s_clken_q   <= 1'b0;
            s_wren_q    <= 1'b0;
            s_byteena_q <= {(DATA_W/8){1'b0}};
            s_address_q <= {ADDR_W{1'b0}};
            s_data_q    <= {DATA_W{1'b0}};
            m0_ack_q    <= 1'b0;
            m1_ack_q    <= 1'b0;
            m0_rdata_q  <= {DATA_W{1'b0}};
            m1_rdata_q  <= {DATA_W{1'b0}};
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            lat_q       <= lat_d;
            sel_q       <= sel_d;
            rr_last_q   <= rr_last_d;
            s_clken_q   <= s_clken_d;
            s_wren_q    <= s_wren_d;
            s_byteena_q <= s_byteena_d;
            s_address_q <= s_address_d;
            s_data_q    <= s_data_d;
            m0_ack_q    <= m0_ack_d;
            m1_ack_q    <= m1_ack_d;
            m0_rdata_q  <= m0_rdata_d;
            m1_rdata_q  <= m1_rdata_d;
            busy_q      <= busy_d;
        end
    end

    assign s_clken   = s_clken_q;
    assign s_wren    = s_wren_q;
    assign s_byteena = s_byteena_q;
    assign s_address = s_address_q;
    assign s_data    = s_data_q;
    assign m0_ack    = m0_ack_q;
    assign m1_ack    = m1_ack_q;
    assign m0_q      = m0_rdata_q;
    assign m1_q      = m1_rdata_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mmio_arbiter.sv
// Scoreboard bench for mmio_arbiter: drivers push expected responses into
// per-master queues, a monitor pops and compares on every ack and also checks
// strobe shape, ack latency, busy and round-robin fairness.
module tb_mmio_arbiter;

    logic        clock;
    logic        reset_n;
    logic        m0_req, m1_req;
    logic [13:0] m0_address, m1_address;
    logic [3:0]  m0_byteena, m1_byteena;
    logic [31:0] m0_data, m1_data;
    logic        m0_wren, m1_wren;
    logic        m0_ack, m1_ack;
    logic [31:0] m0_q, m1_q;
    logic [13:0] s_address;
    logic [3:0]  s_byteena;
    logic [31:0] s_data;
    logic        s_wren, s_clken;
    logic [31:0] s_q = 32'd0;
    logic        busy;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        is_rd;
        logic [31:0] data;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    logic [31:0] ref_mem [16];   // reference register file (16 mapped words)
    logic [31:0] slv_mem [16];   // the slave's own storage

    mmio_arbiter dut (
        .clock(clock), .reset_n(reset_n),
        .m0_req(m0_req), .m0_address(m0_address), .m0_byteena(m0_byteena),
        .m0_data(m0_data), .m0_wren(m0_wren), .m0_ack(m0_ack), .m0_q(m0_q),
        .m1_req(m1_req), .m1_address(m1_address), .m1_byteena(m1_byteena),
        .m1_data(m1_data), .m1_wren(m1_wren), .m1_ack(m1_ack), .m1_q(m1_q),
        .s_address(s_address), .s_byteena(s_byteena), .s_data(s_data),
        .s_wren(s_wren), .s_clken(s_clken), .s_q(s_q), .busy(busy)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
        end
        return r;
    endfunction

    // Slave: registered inputs, one-cycle read latency, unmapped reads return 0.
    always @(posedge clock) begin
        if (s_clken) begin
            if (s_address < 14'd16) begin
                s_q <= slv_mem[s_address[3:0]];
                if (s_wren) slv_mem[s_address[3:0]] <= merge(slv_mem[s_address[3:0]], s_data, s_byteena);
            end else begin
                s_q <= 32'd0;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One transaction from master m: push expectation, hold req until ack.
    task automatic drive(input int m, input logic [13:0] a, input logic w,
                         input logic [3:0] be, input logic [31:0] d);
        exp_t e;
        logic got;
        @(negedge clock);
        e.is_rd = ~w;
        e.data  = 32'd0;
        if (a < 14'd16) begin
            if (w) ref_mem[int'(a)] = merge(ref_mem[int'(a)], d, be);
            else   e.data = ref_mem[int'(a)];
        end
        if (m == 0) begin
            q0.push_back(e);
            m0_address = a; m0_wren = w; m0_byteena = be; m0_data = d; m0_req = 1'b1;
        end else begin
            q1.push_back(e);
            m1_address = a; m1_wren = w; m1_byteena = be; m1_data = d; m1_req = 1'b1;
        end
        got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clock);
            if ((m == 0) ? m0_ack : m1_ack) got = 1'b1;
        end
        chk($sformatf("ack_seen_m%0d", m), 32'(got), 32'd1);
        if (m == 0) m0_req = 1'b0;
        else        m1_req = 1'b0;
    endtask

    task automatic rand_master(input int m, input int n);
        logic [13:0] a;
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 3)) @(negedge clock);
            if ($urandom_range(0, 7) == 0) a = 14'h0100 + 14'($urandom_range(0, 255));
            else                           a = 14'(((m == 1) ? 8 : 0) + $urandom_range(0, 7));
            drive(m, a, 1'($urandom_range(0, 1)), 4'($urandom), $urandom);
        end
    endtask

    task automatic pulse_reset();
        @(negedge clock);
        #2 reset_n = 1'b0;
        repeat (2) @(negedge clock);
        #2 reset_n = 1'b1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_m0_ack"},    32'(m0_ack), 32'd0);
        chk({tag, "_m1_ack"},    32'(m1_ack), 32'd0);
        chk({tag, "_m0_q"},      m0_q, 32'd0);
        chk({tag, "_m1_q"},      m1_q, 32'd0);
        chk({tag, "_s_clken"},   32'(s_clken), 32'd0);
        chk({tag, "_s_wren"},    32'(s_wren), 32'd0);
        chk({tag, "_s_byteena"}, 32'(s_byteena), 32'd0);
        chk({tag, "_s_address"}, 32'(s_address), 32'd0);
        chk({tag, "_s_data"},    s_data, 32'd0);
        chk({tag, "_busy"},      32'(busy), 32'd0);
    endtask

    // Monitor: samples just after the falling edge, pops the scoreboard on acks.
    int          cyc = 0;
    int          clk_cyc = 0;
    logic        has_clk = 1'b0;
    logic        prev_clk = 1'b0;
    logic        pr0 = 1'b0, pr1 = 1'b0;
    logic [1:0]  gr_req = 2'b00;
    logic        last_who = 1'b1;
    logic [31:0] hold0 = 32'd0, hold1 = 32'd0;

    initial begin
        exp_t e;
        logic who, exp_who, have;
        forever begin
            @(negedge clock);
            #1;
            cyc++;
            if (!reset_n) begin
                has_clk = 1'b0; prev_clk = 1'b0; pr0 = 1'b0; pr1 = 1'b0;
                last_who = 1'b1; hold0 = 32'd0; hold1 = 32'd0;
            end else begin
                if (s_clken) begin
                    chk("clken_single_cycle", 32'(prev_clk), 32'd0);
                    has_clk = 1'b1;
                    clk_cyc = cyc;
                    gr_req  = {pr1, pr0};
                end else begin
                    chk("wren_only_in_issue", {27'd0, s_wren, s_byteena}, 32'd0);
                end
                chk("busy", 32'(busy), 32'(has_clk && (cyc - clk_cyc) <= 2));
                if (m0_ack || m1_ack) begin
                    chk("single_ack", 32'(m0_ack && m1_ack), 32'd0);
                    who = m1_ack;
                    chk("ack_latency", 32'(has_clk && cyc == clk_cyc + 2), 32'd1);
                    chk("grant_had_req", 32'(gr_req != 2'b00), 32'd1);
                    if (gr_req == 2'b11)      exp_who = ~last_who;
                    else if (gr_req == 2'b10) exp_who = 1'b1;
                    else                      exp_who = 1'b0;
                    chk("grant_order", 32'(who), 32'(exp_who));
                    last_who = who;
                    have = (who == 1'b0) ? (q0.size() != 0) : (q1.size() != 0);
                    chk($sformatf("ack_pending_m%0d", who), 32'(have), 32'd1);
                    if (have) begin
                        if (who == 1'b0) e = q0.pop_front();
                        else             e = q1.pop_front();
                        if (e.is_rd) chk($sformatf("rdata_m%0d", who), (who ? m1_q : m0_q), e.data);
                    end
                    if (who == 1'b0) hold0 = m0_q;
                    else             hold1 = m1_q;
                end
                if (!m0_ack) chk("m0_q_hold", m0_q, hold0);
                if (!m1_ack) chk("m1_q_hold", m1_q, hold1);
                prev_clk = s_clken;
                pr0 = m0_req;
                pr1 = m1_req;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = 32'd0;
            slv_mem[i] = 32'd0;
        end
        ref_mem[0] = 32'h0000_02A5;
        slv_mem[0] = 32'h0000_02A5;
        reset_n = 1'b1;
        m0_req = 1'b0; m0_address = 14'd0; m0_byteena = 4'd0; m0_data = 32'd0; m0_wren = 1'b0;
        m1_req = 1'b0; m1_address = 14'd0; m1_byteena = 4'd0; m1_data = 32'd0; m1_wren = 1'b0;
        #1 reset_n = 1'b0;
        #1 chk_all_zero("reset");
        repeat (3) @(negedge clock);
        #2 reset_n = 1'b1;

        // single read of the LED register
        drive(0, 14'h0000, 1'b0, 4'b0000, 32'd0);
        // m1 write then readback
        drive(1, 14'h0001, 1'b1, 4'b0111, 32'h00AB_CDEF);
        drive(1, 14'h0001, 1'b0, 4'b0000, 32'd0);

        // simultaneous held requests from reset: m0, m1, m0, m1
        pulse_reset();
        for (int r = 0; r < 2; r++) begin
            fork
                drive(0, 14'h0000, 1'b0, 4'b0000, 32'd0);
                drive(1, 14'h0001, 1'b0, 4'b0000, 32'd0);
            join
        end

        // partial byte-enable write on a cleared register
        drive(0, 14'h0000, 1'b1, 4'b1111, 32'd0);
        drive(0, 14'h0000, 1'b1, 4'b0001, 32'h0000_03FF);
        drive(0, 14'h0000, 1'b0, 4'b0000, 32'd0);
        chk("partial_be_ref", ref_mem[0], 32'h0000_00FF);

        // reset during WAIT: everything clears at once, no ack follows
        @(negedge clock);
        m0_address = 14'h0003; m0_wren = 1'b0; m0_byteena = 4'b1010; m0_data = 32'h1234_5678;
        m0_req = 1'b1;
        for (int i = 0; i < 20 && !s_clken; i++) @(negedge clock);
        chk("midreset_clken_seen", 32'(s_clken), 32'd1);
        @(negedge clock);
        #2 reset_n = 1'b0;
        #1 chk_all_zero("midreset");
        m0_req = 1'b0;
        repeat (3) @(negedge clock);
        #2 reset_n = 1'b1;
        drive(0, 14'h0003, 1'b0, 4'b0000, 32'd0);

        // idle quiet
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            #2 chk("idle_quiet", {27'd0, s_clken, s_wren, busy, m0_ack, m1_ack}, 32'd0);
        end

        // randomized concurrent traffic, disjoint register halves per master
        fork
            rand_master(0, 40);
            rand_master(1, 40);
        join

        repeat (10) @(negedge clock);
        chk("q0_drained", 32'(q0.size()), 32'd0);
        chk("q1_drained", 32'(q1.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
